digit_serial_subtractor: RTL

Multi-cycle unsigned subtractor that computes X − Y − BorrowIn over N bits, D bits per clock, with the borrow carried across cycles in a register. It pairs with the combinational ripple adder in the arithmetic datapath. Wide operands can be subtracted with a small D-bit subtract slice instead of an N-bit combinational chain. Operands are accepted with a start/ready handshake, and the result is presented with a one-cycle done pulse.

---
 rtl/digit_serial_subtractor.sv | 111 +++++++++++
 1 files changed

// File: rtl/digit_serial_subtractor.sv
// Digit-serial unsigned subtractor: computes X - Y - BorrowIn over N bits,
// D bits per clock, with the borrow carried between digits in a register.
module digit_serial_subtractor #(
  parameter int N = 64,
  parameter int D = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         BorrowIn,
  output logic         Ready,
  output logic         Done,
  output logic [N-1:0] Difference,
  output logic         BorrowOut
);

  localparam int K  = N / D;
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT          stateReg, stateNext;
  logic [N-1:0]   xReg, yReg, resultReg;
  logic [N-1:0]   xShift, yShift, resultShift;
  logic           borrowReg;
  logic [CW-1:0]  digitCnt;
  logic [D:0]     slice;
  logic           accept, lastDigit;

  assign accept    = Ready & Start;
  assign lastDigit = (stateReg == RUN) && (digitCnt == LAST_DIGIT);

  // Bit D of the D+1-bit difference is the borrow out of this digit.
  assign slice = {1'b0, xReg[D-1:0]} - {1'b0, yReg[D-1:0]} - {{D{1'b0}}, borrowReg};

  // Operands shift right so the current digit always sits in the low D bits;
  // finished digits enter the result register from the top.
  generate
    if (K == 1) begin : gSingleDigit
      assign xShift      = '0;
      assign yShift      = '0;
      assign resultShift = slice[D-1:0];
    end else begin : gMultiDigit
      assign xShift      = {{D{1'b0}}, xReg[N-1:D]};
      assign yShift      = {{D{1'b0}}, yReg[N-1:D]};
      assign resultShift = {slice[D-1:0], resultReg[N-1:D]};
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    Ready     = 1'b0;
    Done      = 1'b0;
    case (stateReg)
      IDLE: begin
        Ready = 1'b1;
        if (Start) stateNext = RUN;
      end
      RUN: begin
        if (lastDigit) stateNext = DONE;
      end
      DONE: begin
        Ready     = 1'b1;
        Done      = 1'b1;
        stateNext = Start ? RUN : IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      xReg       <= '0;
      yReg       <= '0;
      resultReg  <= '0;
      borrowReg  <= 1'b0;
      digitCnt   <= '0;
      Difference <= '0;
      BorrowOut  <= 1'b0;
    end else if (accept) begin
      xReg      <= X;
      yReg      <= Y;
      borrowReg <= BorrowIn;
      resultReg <= '0;
      digitCnt  <= '0;
    end else if (stateReg == RUN) begin
      xReg      <= xShift;
      yReg      <= yShift;
      resultReg <= resultShift;
      borrowReg <= slice[D];
      digitCnt  <= digitCnt + 1'b1;
      // Visible outputs only move on the completion edge.
      if (lastDigit) begin
        Difference <= resultShift;
        BorrowOut  <= slice[D];
      end
    end
  end

endmodule
